sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_pkg.sv | 15 +
 rtl/sdram_age_prio.sv | 19 +
 rtl/sdram_arbiter.sv | 109 ++++++++++
 tb/tb_sdram_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: FSM encoding, client indices and the per-client SDRAM address map
package sdram_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  localparam logic [1:0] CLI_M68K = 2'd0;
  localparam logic [1:0] CLI_SPR = 2'd1;
  localparam logic [1:0] CLI_TILES = 2'd2;
  localparam logic [1:0] CLI_THEME = 2'd3;
  localparam logic [3:0][25:0] CLI_BASE = {26'h0080000, 26'h0800000, 26'h0900000, 26'h0000000};
  localparam logic [3:0][18:0] CLI_MASK = {19'h3ffff, 19'h3ffff, 19'h7ffff, 19'h3ffff};
  localparam logic [3:0] CLI_SHIFT = 4'b0110;
  localparam logic [3:0] CLI_BURST = 4'b1110;
  function automatic logic [25:0] map_addr(input logic [1:0] c, input logic [18:0] a);
    return CLI_BASE[c] | (26'(a & CLI_MASK[c]) << CLI_SHIFT[c]);
  endfunction
endpackage

// File: rtl/sdram_age_prio.sv
// sdram_age_prio: one-hot winner pick, starved clients first, then fixed priority
module sdram_age_prio
  import sdram_pkg::*;
#(
  parameter int AGE_MAX = 4,
  parameter int AW = 3
) (
  input  logic [3:0]         pending,
  input  logic [3:0][AW-1:0] age,
  output logic [3:0]         grant
);
  logic [3:0] starved, sel;
  // any starved client masks the fixed-priority candidates; lowest set bit wins
  always_comb begin
    for (int i = 0; i < 4; i++) starved[i] = pending[i] && age[i] >= AW'(AGE_MAX);
    sel = |starved ? starved : pending;
    grant = sel & (~sel + 4'd1);
  end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: four-client aging arbiter in front of an SDRAM read controller
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int AGE_MAX = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [3:0]  cli_req,
  input  logic [75:0] cli_addr,
  output logic [3:0]  cli_valid,
  output logic [31:0] cli_data,
  input  logic        dl_en,
  output logic        sdram_rd,
  output logic        sdram_burst,
  output logic [26:1] sdram_addr,
  input  logic        sdram_ready,
  input  logic [63:0] sdram_dout,
  output logic        busy,
  output logic        timeout_err
);
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_d;
  logic [1:0] rst_sync, gidx;
  logic rst_n, issue, expire, finish, unused_ok;
  logic [3:0] pending, grant, winner;
  logic [3:0][18:0] addr_q;
  logic [3:0][AW-1:0] age;
  logic [CW-1:0] cnt;
  assign rst_n = rst_sync[1];
  assign busy = state != IDLE;
  assign unused_ok = ^sdram_dout[63:32];
  sdram_age_prio #(.AGE_MAX(AGE_MAX), .AW(AW)) u_prio (.pending(pending), .age(age), .grant(grant));
  // assert reset at once, release it only on a clk_sys edge
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  // state register
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // next state plus the grant / abort / completion events
  always_comb begin
    state_d = state;
    issue = 1'b0;
    expire = 1'b0;
    finish = 1'b0;
    gidx = 2'd0;
    for (int i = 3; i >= 0; i--) if (grant[i]) gidx = 2'(i);
    case (state)
      IDLE: begin
        issue = !dl_en && |pending;
        state_d = issue ? ISSUE : IDLE;
      end
      ISSUE, WAIT_DONE: begin
        expire = cnt == CW'(TIMEOUT - 1);
        finish = !expire && state == WAIT_DONE && sdram_ready;
        state_d = expire || finish ? IDLE : state == ISSUE && !sdram_ready ? WAIT_DONE : state;
      end
      default: state_d = IDLE;
    endcase
  end
  // request capture; a same-cycle request beats the grant, an abort re-queues the winner
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      addr_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (cli_req[i]) begin
          pending[i] <= 1'b1;
          addr_q[i] <= cli_addr[19*i +: 19];
        end else if (issue && grant[i]) pending[i] <= 1'b0;
        else if (expire && winner[i]) pending[i] <= 1'b1;
    end
  // ages count lost grants while pending, saturating at AGE_MAX
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) age <= '0;
    else
      for (int i = 0; i < 4; i++)
        age[i] <= !pending[i] || (issue && grant[i]) ? '0 :
                  issue && age[i] != AW'(AGE_MAX) ? age[i] + 1'b1 : age[i];
  // SDRAM command, access timer and client return path
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      winner <= '0;
      cnt <= '0;
      sdram_rd <= 1'b0;
      sdram_burst <= 1'b0;
      sdram_addr <= '0;
      cli_valid <= '0;
      cli_data <= '0;
      timeout_err <= 1'b0;
    end else begin
      cli_valid <= finish ? winner : '0;
      cnt <= issue ? '0 : busy ? cnt + 1'b1 : cnt;
      timeout_err <= timeout_err | expire;
      if (issue) begin
        winner <= grant;
        sdram_addr <= map_addr(gidx, addr_q[gidx]);
        sdram_burst <= CLI_BURST[gidx];
        sdram_rd <= 1'b1;
      end else if (expire || (state == ISSUE && !sdram_ready)) sdram_rd <= 1'b0;
      if (finish)
        cli_data <= winner[CLI_M68K] ? {16'd0, sdram_dout[7:0], sdram_dout[15:8]} : sdram_dout[31:0];
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: random-stimulus bench against a behavioural arbitration model
module tb_sdram_arbiter;
  localparam int AGE_MAX = 4;
  localparam int TIMEOUT = 16;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] cli_req = '0;
  logic [75:0] cli_addr = '0;
  logic [3:0] cli_valid;
  logic [31:0] cli_data;
  logic dl_en = 1'b0;
  logic sdram_rd, sdram_burst;
  logic [26:1] sdram_addr;
  logic sdram_ready = 1'b1;
  logic [63:0] sdram_dout = '0;
  logic busy, timeout_err;
  int cmp = 0;
  int errs = 0;
  bit hang = 0, fix = 0, slow = 0;
  logic rd_prev = 1'b0;
  logic [25:0] iss_a[$];
  logic iss_b[$];
  logic [3:0] val_q[$];
  logic [31:0] dat_q[$];
  logic [63:0] drv_q[$];
  bit m_pend[4];
  int m_age[4];
  logic [18:0] m_addr[4];

  sdram_arbiter #(.AGE_MAX(AGE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cli_req(cli_req), .cli_addr(cli_addr),
    .cli_valid(cli_valid), .cli_data(cli_data), .dl_en(dl_en), .sdram_rd(sdram_rd),
    .sdram_burst(sdram_burst), .sdram_addr(sdram_addr), .sdram_ready(sdram_ready),
    .sdram_dout(sdram_dout), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM controller model: accepts a read, goes busy, returns random data
  initial forever begin
    @(negedge clk_sys); #1;
    if (sdram_rd && !hang) begin
      repeat (2) begin @(negedge clk_sys); #1; end
      sdram_ready = 1'b0;
      repeat (slow ? 8 : $urandom_range(1, 4)) begin @(negedge clk_sys); #1; end
      sdram_dout = {$urandom, $urandom};
      if (fix) sdram_dout[15:0] = 16'h1234;
      drv_q.push_back(sdram_dout);
      sdram_ready = 1'b1;
    end
  end

  // observer: records every issued command and every returned strobe
  initial forever begin
    @(posedge clk_sys); #2;
    if (sdram_rd && !rd_prev) begin
      iss_a.push_back(sdram_addr);
      iss_b.push_back(sdram_burst);
    end
    rd_prev = sdram_rd;
    if (cli_valid != 4'd0) begin
      val_q.push_back(cli_valid);
      dat_q.push_back(cli_data);
    end
  end

  function automatic logic [25:0] exp_addr(int c, logic [18:0] a);
    int unsigned lo = a % (1 << 18);
    case (c)
      0: return 26'(lo);
      1: return 26'(32'h900000 + a * 2);
      2: return 26'(32'h800000 + lo * 2);
      default: return 26'(32'h80000 + lo);
    endcase
  endfunction

  function automatic logic [31:0] exp_data(int c, logic [63:0] d);
    return c == 0 ? 32'(((d & 64'hff) << 8) | ((d >> 8) & 64'hff)) : d[31:0];
  endfunction

  function automatic int m_pick();
    for (int i = 0; i < 4; i++) if (m_pend[i] && m_age[i] >= AGE_MAX) return i;
    for (int i = 0; i < 4; i++) if (m_pend[i]) return i;
    return 0;
  endfunction

  task automatic m_grant(int w);
    for (int i = 0; i < 4; i++)
      m_age[i] = (i == w || !m_pend[i]) ? 0 : (m_age[i] < AGE_MAX ? m_age[i] + 1 : AGE_MAX);
    m_pend[w] = 0;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post(logic [3:0] m, int a = -1);
    @(negedge clk_sys);
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        m_addr[i] = a >= 0 ? 19'(a) : 19'($urandom);
        cli_addr[19*i +: 19] = m_addr[i];
        m_pend[i] = 1;
      end
    cli_req = m;
    @(negedge clk_sys);
    cli_req = '0;
  endtask

  task automatic pop_issue(int c);
    chk("issue_present", iss_a.size() != 0, 1);
    if (iss_a.size() == 0) return;
    chk($sformatf("addr_c%0d", c), iss_a.pop_front(), exp_addr(c, m_addr[c]));
    chk($sformatf("burst_c%0d", c), iss_b.pop_front(), c != 0);
  endtask

  task automatic pop_valid(int c);
    chk("valid_present", val_q.size() != 0 && drv_q.size() != 0, 1);
    if (val_q.size() == 0 || drv_q.size() == 0) return;
    chk($sformatf("valid_c%0d", c), val_q.pop_front(), 64'(1) << c);
    chk($sformatf("data_c%0d", c), dat_q.pop_front(), exp_data(c, drv_q.pop_front()));
  endtask

  task automatic wait_valid(int n);
    for (int k = 0; k < 400 && val_q.size() < n; k++) @(negedge clk_sys);
    chk("wait_valid", val_q.size() >= n, 1);
  endtask

  task automatic drain(int n, bit hold0);
    wait_valid(n);
    for (int k = 0; k < n; k++) begin
      int w = m_pick();
      m_grant(w);
      if (hold0) m_pend[0] = 1;
      pop_issue(w);
      pop_valid(w);
    end
  endtask

  task automatic settle();
    int q = 0;
    for (int k = 0; k < 400 && q < 4; k++) begin
      @(negedge clk_sys);
      q = busy ? 0 : q + 1;
    end
    chk("settle", busy, 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rd"}, sdram_rd, 0);
    chk({tag, "_burst"}, sdram_burst, 0);
    chk({tag, "_addr"}, sdram_addr, 0);
    chk({tag, "_valid"}, cli_valid, 0);
    chk({tag, "_data"}, cli_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_terr"}, timeout_err, 0);
  endtask

  initial begin
    logic [3:0] m;
    int n;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0;
      m_age[i] = 0;
      m_addr[i] = '0;
    end
    repeat (3) @(negedge clk_sys);
    chk_zero("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    post(4'b0010, 'h10);
    chk("lat_n1", sdram_rd, 0);
    @(negedge clk_sys);
    chk("lat_n2", sdram_rd, 1);
    chk("single_addr", sdram_addr, exp_addr(1, 19'h10));
    chk("single_burst", sdram_burst, 1);
    drain(1, 0);
    settle();
    post(4'b1111);
    drain(4, 0);
    settle();
    repeat (6) begin
      m = 4'($urandom_range(1, 15));
      post(m);
      drain($countones(m), 0);
      settle();
    end
    post(4'b1001);
    cli_req = 4'b0001;
    wait_valid(5);
    cli_req = '0;
    settle();
    drain(5, 1);
    m_pend[0] = 0;
    for (int i = 0; i < 4; i++) m_age[i] = 0;
    while (iss_a.size() > 0) begin
      pop_issue(0);
      pop_valid(0);
    end
    hang = 1;
    post(4'b0100);
    n = 0;
    for (int k = 0; k < 40 && !sdram_rd; k++) @(negedge clk_sys);
    while (sdram_rd && n < 40) begin
      n++;
      @(negedge clk_sys);
    end
    chk("to_len", n, TIMEOUT);
    chk("to_err", timeout_err, 1);
    chk("to_noval", val_q.size(), 0);
    pop_issue(2);
    for (int k = 0; k < 4 && !sdram_rd; k++) @(negedge clk_sys);
    hang = 0;
    chk("to_reissue", sdram_rd, 1);
    drain(1, 0);
    settle();
    chk("to_sticky", timeout_err, 1);
    fix = 1;
    post(4'b0001);
    wait_valid(1);
    chk("swap", dat_q.size() > 0 ? dat_q[0] : 32'hdeadbeef, 32'h00003412);
    drain(1, 0);
    fix = 0;
    settle();
    post(4'b1000);
    @(negedge clk_sys);
    dl_en = 1'b1;
    drain(1, 0);
    post(4'b0010);
    repeat (10) @(negedge clk_sys);
    chk("dl_noiss", iss_a.size(), 0);
    chk("dl_noval", val_q.size(), 0);
    chk("dl_idle", busy, 0);
    dl_en = 1'b0;
    drain(1, 0);
    settle();
    slow = 1;
    post(4'b0010);
    for (int k = 0; k < 40 && !sdram_rd; k++) @(negedge clk_sys);
    for (int k = 0; k < 40 && sdram_rd; k++) @(negedge clk_sys);
    chk("rst_inflight", busy, 1);
    pop_issue(1);
    reset_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0;
      m_age[i] = 0;
    end
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    slow = 0;
    repeat (20) @(negedge clk_sys);
    chk("rst_noval", val_q.size(), 0);
    chk("rst_noiss", iss_a.size(), 0);
    drv_q.delete();
    post(4'(1 << $urandom_range(0, 3)));
    drain(1, 0);
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
